// File: rtl/l1d_pkg.sv
// Shared definitions for the L1 data cache: address geometry, FSM states
// and helpers that split a CPU word address into tag/index/offset.
package l1d_pkg;

   localparam int ADDR_W  = 23;
   localparam int INDEX_W = 7;
   localparam int OFFS_W  = 2;
   localparam int TAG_W   = ADDR_W - INDEX_W - OFFS_W;
   localparam int LINES   = 1 << INDEX_W;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      FILL_REQ,
      FILL_WAIT,
      FILL_END,
      WR_REQ,
      WR_WAIT
   } state_t;

   function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
      return a[ADDR_W-1 -: TAG_W];
   endfunction

   function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
      return a[OFFS_W +: INDEX_W];
   endfunction

   function automatic logic [OFFS_W-1:0] addr_offs(input logic [ADDR_W-1:0] a);
      return a[OFFS_W-1:0];
   endfunction

endpackage

// File: rtl/l1d_dpram.sv
// Single-port synchronous RAM with a registered read (one cycle latency).
// Used for both the data array and the tag array of the cache.
module l1d_dpram #(
   parameter int DEPTH_W = 9,
   parameter int DATA_W  = 32
) (
   input  logic               clk_i,
   input  logic               we_i,
   input  logic [DEPTH_W-1:0] addr_i,
   input  logic [DATA_W-1:0]  wdata_i,
   output logic [DATA_W-1:0]  rdata_o
);

   logic [DATA_W-1:0] mem_q [1 << DEPTH_W];
   logic [DATA_W-1:0] rdata_q;

   // Write when enabled; always register the addressed word for the next cycle.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
      rdata_q <= mem_q[addr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/l1d_cache.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache.
// Read misses fill the whole 4-word line with single-word SDRAM reads;
// every write is forwarded to SDRAM and only updates the cache on a hit.
module l1d_cache
   import l1d_pkg::*;
(
   input  logic              clk100,
   input  logic              reset,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic              cpu_start,
   input  logic              cpu_we,
   input  logic [31:0]       cpu_data,
   output logic [31:0]       cpu_q,
   output logic              cpu_done,
   output logic              cpu_ready,
   output logic [ADDR_W-1:0] sdc_addr,
   output logic              sdc_start,
   output logic              sdc_we,
   output logic [31:0]       sdc_data,
   input  logic [31:0]       sdc_q,
   input  logic              sdc_done
);

   state_t               state_q;
   logic [ADDR_W-1:0]    addr_q;
   logic                 we_q;
   logic [31:0]          data_q;
   logic [OFFS_W-1:0]    cnt_q;
   logic [LINES-1:0]     valid_q;
   logic [31:0]          cpu_q_q;
   logic                 cpu_done_q;
   logic                 cpu_ready_q;
   logic                 sdc_start_q;
   logic                 sdc_we_q;
   logic [ADDR_W-1:0]    sdc_addr_q;
   logic [31:0]          sdc_data_q;

   logic [TAG_W-1:0]          tag_l;
   logic [INDEX_W-1:0]        idx_l;
   logic [OFFS_W-1:0]         off_l;
   logic [INDEX_W+OFFS_W-1:0] data_addr;
   logic                      data_we;
   logic [31:0]               data_wd;
   logic [31:0]               data_rd;
   logic [INDEX_W-1:0]        tag_addr;
   logic                      tag_we;
   logic [TAG_W-1:0]          tag_rd;
   logic                      hit;

   assign tag_l = addr_tag(addr_q);
   assign idx_l = addr_index(addr_q);
   assign off_l = addr_offs(addr_q);
   assign hit   = valid_q[idx_l] && (tag_rd == tag_l);

   // RAM port steering: IDLE reads with the incoming address so the tag and
   // data words are ready in LOOKUP; later states use the latched address.
   always_comb begin
      data_addr = {idx_l, off_l};
      data_we   = 1'b0;
      data_wd   = data_q;
      tag_addr  = idx_l;
      tag_we    = 1'b0;
      case (state_q)
         IDLE: begin
            data_addr = {addr_index(cpu_addr), addr_offs(cpu_addr)};
            tag_addr  = addr_index(cpu_addr);
         end
         LOOKUP: begin
            data_we = we_q && hit;
         end
         FILL_WAIT: begin
            data_addr = {idx_l, cnt_q};
            data_wd   = sdc_q;
            data_we   = sdc_done;
            tag_we    = sdc_done && (cnt_q == 2'd3);
         end
         default: begin
         end
      endcase
   end

   l1d_dpram #(.DEPTH_W(INDEX_W + OFFS_W), .DATA_W(32)) u_data (
      .clk_i   (clk100),
      .we_i    (data_we),
      .addr_i  (data_addr),
      .wdata_i (data_wd),
      .rdata_o (data_rd)
   );

   l1d_dpram #(.DEPTH_W(INDEX_W), .DATA_W(TAG_W)) u_tag (
      .clk_i   (clk100),
      .we_i    (tag_we),
      .addr_i  (tag_addr),
      .wdata_i (tag_l),
      .rdata_o (tag_rd)
   );

   // Control FSM with registered CPU/SDRAM outputs and the valid-bit array.
   always_ff @(posedge clk100 or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         we_q        <= 1'b0;
         data_q      <= '0;
         cnt_q       <= '0;
         valid_q     <= '0;
         cpu_q_q     <= '0;
         cpu_done_q  <= 1'b0;
         cpu_ready_q <= 1'b1;
         sdc_start_q <= 1'b0;
         sdc_we_q    <= 1'b0;
         sdc_addr_q  <= '0;
         sdc_data_q  <= '0;
      end else begin
         cpu_done_q  <= 1'b0;
         sdc_start_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (cpu_start) begin
                  addr_q      <= cpu_addr;
                  we_q        <= cpu_we;
                  data_q      <= cpu_data;
                  cpu_ready_q <= 1'b0;
                  state_q     <= LOOKUP;
               end
            end
            LOOKUP: begin
               if (we_q) begin
                  state_q <= WR_REQ;
               end else if (hit) begin
                  cpu_q_q     <= data_rd;
                  cpu_done_q  <= 1'b1;
                  cpu_ready_q <= 1'b1;
                  state_q     <= IDLE;
               end else begin
                  valid_q[idx_l] <= 1'b0;
                  cnt_q          <= '0;
                  state_q        <= FILL_REQ;
               end
            end
            FILL_REQ: begin
               sdc_start_q <= 1'b1;
               sdc_we_q    <= 1'b0;
               sdc_addr_q  <= {tag_l, idx_l, cnt_q};
               state_q     <= FILL_WAIT;
            end
            FILL_WAIT: begin
               if (sdc_done) begin
                  if (cnt_q == off_l) begin
                     cpu_q_q <= sdc_q;
                  end
                  if (cnt_q == 2'd3) begin
                     valid_q[idx_l] <= 1'b1;
                     state_q        <= FILL_END;
                  end else begin
                     cnt_q   <= cnt_q + 2'd1;
                     state_q <= FILL_REQ;
                  end
               end
            end
            FILL_END: begin
               cpu_done_q  <= 1'b1;
               cpu_ready_q <= 1'b1;
               state_q     <= IDLE;
            end
            WR_REQ: begin
               sdc_start_q <= 1'b1;
               sdc_we_q    <= 1'b1;
               sdc_addr_q  <= addr_q;
               sdc_data_q  <= data_q;
               state_q     <= WR_WAIT;
            end
            WR_WAIT: begin
               if (sdc_done) begin
                  cpu_done_q  <= 1'b1;
                  cpu_ready_q <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               cpu_ready_q <= 1'b1;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign cpu_q     = cpu_q_q;
   assign cpu_done  = cpu_done_q;
   assign cpu_ready = cpu_ready_q;
   assign sdc_start = sdc_start_q;
   assign sdc_we    = sdc_we_q;
   assign sdc_addr  = sdc_addr_q;
   assign sdc_data  = sdc_data_q;

endmodule

// File: tb/tb_l1d_cache.sv
// Self-checking bench for l1d_cache: table of CPU transactions with a
// behavioural SDRAM, a scoreboard of expected read data, and hand-written
// sequences for a busy-time start and a reset in the middle of a fill.
module tb_l1d_cache;

   logic        clk100;
   logic        reset;
   logic [22:0] cpu_addr;
   logic        cpu_start;
   logic        cpu_we;
   logic [31:0] cpu_data;
   logic [31:0] cpu_q;
   logic        cpu_done;
   logic        cpu_ready;
   logic [22:0] sdc_addr;
   logic        sdc_start;
   logic        sdc_we;
   logic [31:0] sdc_data;
   logic [31:0] sdc_q;
   logic        sdc_done;

   l1d_cache dut (
      .clk100    (clk100),
      .reset     (reset),
      .cpu_addr  (cpu_addr),
      .cpu_start (cpu_start),
      .cpu_we    (cpu_we),
      .cpu_data  (cpu_data),
      .cpu_q     (cpu_q),
      .cpu_done  (cpu_done),
      .cpu_ready (cpu_ready),
      .sdc_addr  (sdc_addr),
      .sdc_start (sdc_start),
      .sdc_we    (sdc_we),
      .sdc_data  (sdc_data),
      .sdc_q     (sdc_q),
      .sdc_done  (sdc_done)
   );

   initial clk100 = 1'b0;
   always #5 clk100 = ~clk100;

   typedef struct {
      logic [22:0] addr;
      logic        we;
      logic [31:0] data;
      logic [31:0] exp_q;
      int          exp_rd;
      int          exp_wr;
      bit          hit;
   } vec_t;

   typedef struct {
      logic        we;
      logic [22:0] addr;
      logic [31:0] data;
   } sdc_req_t;

   int          tests = 0;
   int          fails = 0;
   int          done_cnt = 0;
   int          sd_lat = 2;
   sdc_req_t    sdc_log[$];
   logic [31:0] exp_q_sb[$];
   logic [31:0] sd_mem [logic [22:0]];
   vec_t        vecs[12];

   function automatic logic [31:0] sd_read(input logic [22:0] a);
      if (sd_mem.exists(a)) return sd_mem[a];
      return 32'hC000_0000 | {9'd0, a};
   endfunction

   task automatic check(input string name, input logic [22:0] a,
                        input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s addr=%h: got %h, want %h", name, a, act, exp);
      end
   endtask

   // Count CPU completion pulses, sampled mid-cycle.
   always @(negedge clk100) begin
      if (cpu_done === 1'b1) done_cnt <= done_cnt + 1;
   end

   // Behavioural SDRAM: one request at a time, done sd_lat cycles later.
   initial begin
      sdc_req_t r;
      logic [31:0] rd;
      sdc_done = 1'b0;
      sdc_q    = '0;
      forever begin
         @(negedge clk100);
         if (sdc_start === 1'b1) begin
            r.we = sdc_we; r.addr = sdc_addr; r.data = sdc_data;
            sdc_log.push_back(r);
            if (r.we) sd_mem[r.addr] = r.data;
            rd = sd_read(r.addr);
            repeat (sd_lat) @(negedge clk100);
            sdc_q    = rd;
            sdc_done = 1'b1;
            @(negedge clk100);
            sdc_done = 1'b0;
         end
      end
   end

   task automatic do_op(input vec_t v, input bit poke);
      int n0, d0, lat, w, rdk, wrk;
      logic [31:0] exp;
      n0 = sdc_log.size();
      d0 = done_cnt;
      w  = 0;
      while (cpu_ready !== 1'b1 && w < 50) begin
         @(posedge clk100); #1; w++;
      end
      cpu_addr  = v.addr;
      cpu_we    = v.we;
      cpu_data  = v.data;
      cpu_start = 1'b1;
      exp_q_sb.push_back(v.exp_q);
      @(posedge clk100); #1;
      cpu_start = 1'b0;
      lat = 1;
      check("ready_low_busy", v.addr, 32'(cpu_ready), 32'd0);
      while (cpu_done !== 1'b1 && lat < 200) begin
         if (poke && lat == 3) begin
            cpu_start = 1'b1; cpu_we = 1'b1; cpu_addr = 23'h000020;
         end
         @(posedge clk100); #1;
         cpu_start = 1'b0;
         lat++;
      end
      exp = exp_q_sb.pop_front();
      if (cpu_done !== 1'b1) begin
         check("done_timeout", v.addr, 32'd0, 32'd1);
      end else begin
         check("cpu_q", v.addr, cpu_q, exp);
         if (v.hit) check("hit_latency", v.addr, 32'(lat), 32'd2);
      end
      @(posedge clk100); #1;
      check("ready_after", v.addr, 32'(cpu_ready), 32'd1);
      repeat (3) @(posedge clk100);
      #1;
      check("done_pulses", v.addr, 32'(done_cnt - d0), 32'd1);
      rdk = 0;
      wrk = 0;
      for (int k = n0; k < sdc_log.size(); k++) begin
         if (sdc_log[k].we) begin
            check("sdc_wr_addr", v.addr, 32'(sdc_log[k].addr), 32'(v.addr));
            check("sdc_wr_data", v.addr, sdc_log[k].data, v.data);
            wrk++;
         end else begin
            check("sdc_rd_addr", v.addr, 32'(sdc_log[k].addr),
                  32'({v.addr[22:2], rdk[1:0]}));
            rdk++;
         end
      end
      check("sdc_reads", v.addr, 32'(rdk), 32'(v.exp_rd));
      check("sdc_writes", v.addr, 32'(wrk), 32'(v.exp_wr));
      $display("[TB] op %s addr=%h q=%h lat=%0d rd=%0d wr=%0d",
               v.we ? "WR" : "RD", v.addr, cpu_q, lat, rdk, wrk);
   endtask

   initial begin
      vec_t v;
      int   n0, d0, w;

      //         addr        we    data          exp_q         rd wr hit
      vecs[0]  = '{23'h000005, 1'b0, 32'h0,        32'h0000_00A1, 4, 0, 1'b0};
      vecs[1]  = '{23'h000006, 1'b0, 32'h0,        32'h0000_00A2, 0, 0, 1'b1};
      vecs[2]  = '{23'h000006, 1'b1, 32'h0000DEAD, 32'h0000_00A2, 0, 1, 1'b0};
      vecs[3]  = '{23'h000006, 1'b0, 32'h0,        32'h0000_DEAD, 0, 0, 1'b1};
      vecs[4]  = '{23'h7F0000, 1'b1, 32'h12345678, 32'h0000_DEAD, 0, 1, 1'b0};
      vecs[5]  = '{23'h7F0000, 1'b0, 32'h0,        32'h1234_5678, 4, 0, 1'b0};
      vecs[6]  = '{23'h000004, 1'b0, 32'h0,        32'h0000_00A0, 0, 0, 1'b1};
      vecs[7]  = '{23'h000204, 1'b0, 32'h0,        32'hC000_0204, 4, 0, 1'b0};
      vecs[8]  = '{23'h000004, 1'b0, 32'h0,        32'h0000_00A0, 4, 0, 1'b0};
      vecs[9]  = '{23'h000007, 1'b0, 32'h0,        32'h0000_00A3, 0, 0, 1'b1};
      vecs[10] = '{23'h000100, 1'b1, 32'h00000055, 32'h0000_00A3, 0, 1, 1'b0};
      vecs[11] = '{23'h000100, 1'b0, 32'h0,        32'h0000_0055, 4, 0, 1'b0};

      sd_mem[23'h000004] = 32'h0000_00A0;
      sd_mem[23'h000005] = 32'h0000_00A1;
      sd_mem[23'h000006] = 32'h0000_00A2;
      sd_mem[23'h000007] = 32'h0000_00A3;

      reset = 1'b0; cpu_addr = '0; cpu_start = 1'b0; cpu_we = 1'b0; cpu_data = '0;
      #23;
      check("rst_ready", 23'h0, 32'(cpu_ready), 32'd1);
      check("rst_done", 23'h0, 32'(cpu_done), 32'd0);
      check("rst_q", 23'h0, cpu_q, 32'd0);
      check("rst_sdc_start", 23'h0, 32'(sdc_start), 32'd0);
      check("rst_sdc_we", 23'h0, 32'(sdc_we), 32'd0);
      check("rst_sdc_addr", 23'h0, 32'(sdc_addr), 32'd0);
      check("rst_sdc_data", 23'h0, sdc_data, 32'd0);
      @(posedge clk100); #1;
      reset = 1'b1;
      repeat (2) @(posedge clk100);
      #1;

      for (int i = 0; i < 12; i++) do_op(vecs[i], 1'b0);

      // A start while the cache is busy must be dropped, not queued.
      v = '{23'h000010, 1'b0, 32'h0, 32'hC000_0010, 4, 0, 1'b0};
      do_op(v, 1'b1);

      // Reset in the middle of a fill; the late SDRAM done must be ignored.
      sd_lat = 6;
      n0 = sdc_log.size();
      cpu_addr = 23'h000300; cpu_we = 1'b0; cpu_start = 1'b1;
      @(posedge clk100); #1;
      cpu_start = 1'b0;
      w = 0;
      while (sdc_log.size() == n0 && w < 50) begin
         @(posedge clk100); #1; w++;
      end
      check("fill_started", 23'h000300, 32'(sdc_log.size() - n0), 32'd1);
      @(posedge clk100); #1;
      reset = 1'b0;
      #1;
      check("midrst_ready", 23'h000300, 32'(cpu_ready), 32'd1);
      check("midrst_q", 23'h000300, cpu_q, 32'd0);
      check("midrst_sdc_start", 23'h000300, 32'(sdc_start), 32'd0);
      repeat (2) @(posedge clk100);
      #1;
      reset = 1'b1;
      d0 = done_cnt;
      n0 = sdc_log.size();
      repeat (12) @(posedge clk100);
      #1;
      check("late_done_no_cpu_done", 23'h000300, 32'(done_cnt - d0), 32'd0);
      check("late_done_no_sdc", 23'h000300, 32'(sdc_log.size() - n0), 32'd0);
      check("late_done_ready", 23'h000300, 32'(cpu_ready), 32'd1);
      $display("[TB] mid-fill reset done, cpu_ready=%0b", cpu_ready);
      sd_lat = 2;

      // Valid bits were cleared by the reset, so both lines refill.
      v = '{23'h000005, 1'b0, 32'h0, 32'h0000_00A1, 4, 0, 1'b0};
      do_op(v, 1'b0);
      v = '{23'h000300, 1'b0, 32'h0, 32'hC000_0300, 4, 0, 1'b0};
      do_op(v, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
